// File: rtl/cache_tag_ctrl.sv
// N-way set-associative tag controller: registered lookup, true-LRU victim,
// write-back dirty tracking, miss sequencing and a dirty-line flush walker.
module cache_tag_ctrl #(
    parameter  int WAYS   = 4,
    parameter  int SETS   = 16,
    parameter  int ADDR_W = 32,
    parameter  int OFF_W  = 6,
    localparam int SET_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS),
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_vwrite,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [SET_W-1:0]  resp_set,
    output logic              wb_req,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_done,
    output logic              refill_req,
    output logic [ADDR_W-1:0] refill_addr,
    input  logic              refill_done,
    input  logic              flush,
    input  logic              invalidate,
    output logic              busy,
    output logic              flush_done
);

    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int PTR_W  = SET_W + WAY_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOOKUP     = 3'd1;
    localparam logic [2:0] S_MISS_WB    = 3'd2;
    localparam logic [2:0] S_MISS_FILL  = 3'd3;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] S_FLUSH_WB   = 3'd5;

    typedef logic [WAYS-1:0][WAY_W-1:0] rank_row_t;

    logic [2:0]                           state_q, state_d;
    logic [LINE_W-1:0]                    line_q, line_d;
    logic                                 vwrite_q, vwrite_d;
    logic [WAY_W-1:0]                     victim_q, victim_d;
    logic [PTR_W-1:0]                     ptr_q, ptr_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]            dirty_q, dirty_d;
    rank_row_t [SETS-1:0]                 rank_q, rank_d;

    logic [SET_W-1:0] lk_set;
    logic [TAG_W-1:0] lk_tag;
    logic [SET_W-1:0] fl_set;
    logic [WAY_W-1:0] fl_way;
    logic             fl_last;
    logic             fl_dirty;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_sel;
    logic             unused_off;

    assign unused_off = ^req_addr[OFF_W-1:0];

    assign lk_set   = line_q[SET_W-1:0];
    assign lk_tag   = line_q[LINE_W-1:SET_W];
    assign fl_set   = ptr_q[PTR_W-1:WAY_W];
    assign fl_way   = ptr_q[WAY_W-1:0];
    assign fl_last  = &ptr_q;
    assign fl_dirty = valid_q[fl_set][fl_way] & dirty_q[fl_set][fl_way];

    // Touched way becomes rank 0; only ways more recent than it age by one.
    function automatic rank_row_t lru_touch(input rank_row_t row,
                                            input logic [WAY_W-1:0] w);
        rank_row_t r;
        r = row;
        for (int i = 0; i < WAYS; i++) begin
            if (row[i] < row[w]) r[i] = row[i] + 1'b1;
        end
        r[w] = '0;
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[lk_set][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (rank_q[lk_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
    end

    assign victim_sel = inv_any ? inv_way : lru_way;

    assign busy      = state_q != S_IDLE;
    assign req_ready = (state_q == S_IDLE) & ~flush & ~invalidate;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        vwrite_d    = vwrite_q;
        victim_d    = victim_q;
        ptr_d       = ptr_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rank_d      = rank_q;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_way    = '0;
        resp_set    = '0;
        wb_req      = 1'b0;
        wb_addr     = '0;
        refill_req  = 1'b0;
        refill_addr = '0;
        flush_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (invalidate) begin
                    valid_d = '0;
                    dirty_d = '0;
                end else if (flush) begin
                    ptr_d   = '0;
                    state_d = S_FLUSH_SCAN;
                end else if (req_valid && req_ready) begin
                    line_d   = req_addr[ADDR_W-1:OFF_W];
                    vwrite_d = req_vwrite;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid               = 1'b1;
                    resp_hit                 = 1'b1;
                    resp_way                 = hit_way;
                    resp_set                 = lk_set;
                    rank_d[lk_set]           = lru_touch(rank_q[lk_set], hit_way);
                    dirty_d[lk_set][hit_way] = dirty_q[lk_set][hit_way] | vwrite_q;
                    state_d                  = S_IDLE;
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[lk_set][victim_sel] && dirty_q[lk_set][victim_sel])
                        state_d = S_MISS_WB;
                    else
                        state_d = S_MISS_FILL;
                end
            end
            S_MISS_WB: begin
                wb_req  = 1'b1;
                wb_addr = {tag_q[lk_set][victim_q], lk_set, {OFF_W{1'b0}}};
                if (wb_done) begin
                    valid_d[lk_set][victim_q] = 1'b0;
                    dirty_d[lk_set][victim_q] = 1'b0;
                    state_d                   = S_MISS_FILL;
                end
            end
            S_MISS_FILL: begin
                refill_req  = 1'b1;
                refill_addr = {line_q, {OFF_W{1'b0}}};
                if (refill_done) begin
                    tag_d[lk_set][victim_q]   = lk_tag;
                    valid_d[lk_set][victim_q] = 1'b1;
                    dirty_d[lk_set][victim_q] = vwrite_q;
                    rank_d[lk_set]            = lru_touch(rank_q[lk_set], victim_q);
                    resp_valid                = 1'b1;
                    resp_way                  = victim_q;
                    resp_set                  = lk_set;
                    state_d                   = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                if (fl_dirty) begin
                    state_d = S_FLUSH_WB;
                end else if (fl_last) begin
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                wb_req  = 1'b1;
                wb_addr = {tag_q[fl_set][fl_way], fl_set, {OFF_W{1'b0}}};
                if (wb_done) begin
                    dirty_d[fl_set][fl_way] = 1'b0;
                    if (fl_last) begin
                        flush_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_FLUSH_SCAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            vwrite_q <= 1'b0;
            victim_q <= '0;
            ptr_q    <= '0;
            tag_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    rank_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            vwrite_q <= vwrite_d;
            victim_q <= victim_d;
            ptr_q    <= ptr_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            rank_q   <= rank_d;
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed and randomized bench for cache_tag_ctrl against a recency-stamp
// reference model of the tag store.
module tb_cache_tag_ctrl;

    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 6;
    localparam int SET_W  = 4;
    localparam int WAY_W  = 2;
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_vwrite = 1'b0;
    logic              resp_valid;
    logic              resp_hit;
    logic [WAY_W-1:0]  resp_way;
    logic [SET_W-1:0]  resp_set;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_done = 1'b0;
    logic              refill_req;
    logic [ADDR_W-1:0] refill_addr;
    logic              refill_done = 1'b0;
    logic              flush = 1'b0;
    logic              invalidate = 1'b0;
    logic              busy;
    logic              flush_done;

    int errors = 0;
    int checks = 0;

    // Reference model: recency expressed as a global touch counter per line
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    bit               m_valid [SETS][WAYS];
    bit               m_dirty [SETS][WAYS];
    int unsigned      m_stamp [SETS][WAYS];
    int unsigned      now = 0;

    logic [ADDR_W-1:0] wb_seen[$];

    cache_tag_ctrl #(
        .WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_vwrite(req_vwrite),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_set(resp_set),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
        .refill_req(refill_req), .refill_addr(refill_addr),
        .refill_done(refill_done),
        .flush(flush), .invalidate(invalidate),
        .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
        end
    endfunction

    function automatic void touch(input int s, input int w);
        now++;
        m_stamp[s][w] = now;
    endfunction

    // Lowest invalid way first, otherwise the least recently used line
    function automatic int victim(input int s);
        int best;
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        best = 0;
        for (int w = 1; w < WAYS; w++) begin
            if (m_stamp[s][w] < m_stamp[s][best]) best = w;
        end
        return best;
    endfunction

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        invalidate = 1'b0;
        wb_done = 1'b0;
        refill_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_invalidate();
        tick();
        invalidate = 1'b1;
        @(negedge clk);
        chk("inval req_ready", req_ready, 0);
        tick();
        invalidate = 1'b0;
        @(negedge clk);
        chk("inval busy", busy, 0);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic access(input logic [ADDR_W-1:0] a, input bit vw,
                          input int wlat, input int rlat,
                          output bit o_hit, output int o_way,
                          output bit o_wb, output logic [ADDR_W-1:0] o_wba);
        int s;
        int hw;
        int vict;
        bit m_hit;
        bit m_wb;
        logic [TAG_W-1:0] t;
        logic [ADDR_W-1:0] line;
        logic [ADDR_W-1:0] old;
        s = int'(a[OFF_W +: SET_W]);
        t = a[ADDR_W-1 -: TAG_W];
        line = {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        m_hit = 1'b0;
        hw = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                m_hit = 1'b1;
                hw = w;
            end
        end
        o_hit = 1'b0;
        o_way = 0;
        o_wb = 1'b0;
        o_wba = '0;
        tick();
        req_valid = 1'b1;
        req_addr = a;
        req_vwrite = vw;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lookup resp_valid", resp_valid, m_hit);
        if (m_hit) begin
            chk("hit resp_hit", resp_hit, 1);
            chk("hit way", resp_way, hw);
            chk("hit set", resp_set, s);
            chk("hit no wb_req", wb_req, 0);
            chk("hit no refill_req", refill_req, 0);
            o_hit = resp_hit;
            o_way = int'(resp_way);
            touch(s, hw);
            m_dirty[s][hw] = m_dirty[s][hw] | vw;
            return;
        end
        vict = victim(s);
        m_wb = m_valid[s][vict] && m_dirty[s][vict];
        old = {m_tag[s][vict], SET_W'(s), {OFF_W{1'b0}}};
        tick();
        @(negedge clk);
        chk("miss wb_req", wb_req, m_wb);
        chk("miss refill_req", refill_req, !m_wb);
        if (m_wb) begin
            o_wb = 1'b1;
            o_wba = wb_addr;
            chk("wb_addr", wb_addr, old);
            repeat (wlat) begin
                tick();
                @(negedge clk);
                chk("wb_req held", wb_req, 1);
                chk("no refill during wb", refill_req, 0);
            end
            tick();
            wb_done = 1'b1;
            @(negedge clk);
            chk("wb_req at done", wb_req, 1);
            tick();
            wb_done = 1'b0;
            @(negedge clk);
            chk("wb_req dropped", wb_req, 0);
            chk("refill after wb", refill_req, 1);
            m_valid[s][vict] = 1'b0;
            m_dirty[s][vict] = 1'b0;
        end
        chk("refill_addr", refill_addr, line);
        repeat (rlat) begin
            tick();
            @(negedge clk);
            chk("refill_req held", refill_req, 1);
            chk("no resp while filling", resp_valid, 0);
        end
        tick();
        refill_done = 1'b1;
        @(negedge clk);
        chk("fill resp_valid", resp_valid, 1);
        chk("fill resp_hit", resp_hit, 0);
        chk("fill way", resp_way, vict);
        chk("fill set", resp_set, s);
        o_hit = resp_hit;
        o_way = int'(resp_way);
        tick();
        refill_done = 1'b0;
        @(negedge clk);
        chk("resp pulse ends", resp_valid, 0);
        chk("refill_req dropped", refill_req, 0);
        chk("idle after fill", busy, 0);
        m_tag[s][vict] = t;
        m_valid[s][vict] = 1'b1;
        m_dirty[s][vict] = vw;
        touch(s, vict);
    endtask

    task automatic do_flush(input int lat);
        logic [ADDR_W-1:0] exp_q[$];
        bit fin;
        int wcnt;
        exp_q = {};
        wb_seen = {};
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[s][w] && m_dirty[s][w])
                    exp_q.push_back({m_tag[s][w], SET_W'(s), {OFF_W{1'b0}}});
            end
        end
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush req_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        fin = 1'b0;
        wcnt = -1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk);
            if (flush_done) fin = 1'b1;
            if (wb_req && !wb_done && wcnt < 0) begin
                wb_seen.push_back(wb_addr);
                chk("flush wb expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("flush wb addr", wb_addr, exp_q.pop_front());
                wcnt = lat;
            end
            tick();
            wb_done = 1'b0;
            if (wcnt == 0) begin
                wb_done = 1'b1;
                wcnt = -1;
            end else if (wcnt > 0) begin
                wcnt--;
            end
        end
        wb_done = 1'b0;
        chk("flush_done seen", fin, 1);
        chk("flush wb remaining", exp_q.size(), 0);
        @(negedge clk);
        chk("flush idle", busy, 0);
        chk("flush_done pulse", flush_done, 0);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) m_dirty[s][w] = 1'b0;
        end
    endtask

    bit h;
    bit wb;
    int wy;
    int r;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;

    initial begin
        model_reset();
        do_reset();
        @(negedge clk);
        chk("rst req_ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst wb_req", wb_req, 0);
        chk("rst refill_req", refill_req, 0);
        chk("rst busy", busy, 0);
        chk("rst flush_done", flush_done, 0);

        // cold miss, then hit on the same line
        access(32'h0000_1040, 1'b0, 0, 2, h, wy, wb, wa);
        chk("t1 miss", h, 0);
        chk("t1 way", wy, 0);
        access(32'h0000_1040, 1'b0, 0, 0, h, wy, wb, wa);
        chk("t2 hit", h, 1);
        chk("t2 way", wy, 0);

        // LRU victim in set 1
        access(32'h0000_1440, 1'b0, 0, 1, h, wy, wb, wa);
        access(32'h0000_1840, 1'b0, 0, 1, h, wy, wb, wa);
        access(32'h0000_1C40, 1'b0, 0, 1, h, wy, wb, wa);
        access(32'h0000_1040, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_2040, 1'b0, 0, 1, h, wy, wb, wa);
        chk("t3 victim way", wy, 1);
        chk("t3 no wb", wb, 0);

        // dirty eviction
        access(32'h0000_2040, 1'b1, 0, 0, h, wy, wb, wa);
        chk("t4 vwrite hit", h, 1);
        chk("t4 vwrite way", wy, 1);
        access(32'h0000_1840, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_1C40, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_1040, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_2440, 1'b0, 5, 1, h, wy, wb, wa);
        chk("t4 wb seen", wb, 1);
        chk("t4 wb addr", wa, 32'h0000_2040);
        chk("t4 refill way", wy, 1);

        // flush of (set2,way3) and (set7,way0)
        access(32'h0000_0480, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_0880, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_0C80, 1'b0, 0, 0, h, wy, wb, wa);
        access(32'h0000_1080, 1'b1, 0, 0, h, wy, wb, wa);
        chk("t5 dirty way", wy, 3);
        access(32'h0000_41C0, 1'b1, 0, 0, h, wy, wb, wa);
        do_flush(2);
        chk("t5 wb count", wb_seen.size(), 2);
        if (wb_seen.size() == 2) begin
            chk("t5 first wb", wb_seen[0], 32'h0000_1080);
            chk("t5 second wb", wb_seen[1], 32'h0000_41C0);
        end
        access(32'h0000_1080, 1'b0, 0, 0, h, wy, wb, wa);
        chk("t5 still valid", h, 1);
        chk("t5 still way", wy, 3);

        // invalidate wins over flush and req
        tick();
        invalidate = 1'b1;
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h0000_1080;
        @(negedge clk);
        chk("t6 req_ready", req_ready, 0);
        tick();
        invalidate = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6 only inval", busy, 0);
        chk("t6 no wb", wb_req, 0);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        access(32'h0000_1080, 1'b0, 0, 0, h, wy, wb, wa);
        chk("t6 miss after inval", h, 0);

        // reset in the middle of a victim write-back
        for (int t = 1; t <= 4; t++) begin
            ra = (t << 10) | (5 << 6);
            access(ra, 1'b1, 0, 0, h, wy, wb, wa);
        end
        tick();
        req_valid = 1'b1;
        req_addr = (5 << 10) | (5 << 6);
        req_vwrite = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t6 wb pending", wb_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6 rst wb_req", wb_req, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst req_ready", req_ready, 1);
        access((1 << 10) | (5 << 6), 1'b0, 0, 0, h, wy, wb, wa);
        chk("t6 cleared miss", h, 0);
        chk("t6 cleared way", wy, 0);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_invalidate();
            end else if (r < 7) begin
                do_flush(int'($urandom_range(0, 3)));
            end else begin
                ra = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 6) |
                     $urandom_range(0, 63);
                access(ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), h, wy, wb, wa);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
